fx2_fifo_master: RTL and testbench
==================================

# fx2_fifo_master

Synthesizable FPGA-side master for the FX2 slave-FIFO bus on the USB_IFCLK domain. It drains the host-to-device OUT endpoint into an RX stream and fills the device-to-host IN endpoint from a TX stream. It drives SLRD, SLWR, SLOE, PKTEND and FIFOADR, and samples FLAGA and FLAGD. It sits between the USB pins and the Wishbone/SDRAM bridge logic inside `fpga`.

## Interface
- `OUT_ADDR`, 2'b00: FIFOADR value that selects the OUT endpoint (EP2).
- `IN_ADDR`, 2'b10: FIFOADR value that selects the IN endpoint (EP6).
- `BURST_MAX`, 256: maximum words per read or write burst before re-arbitration.
- `USB_IFCLK` in 1: the single clock, 48 MHz FX2 interface clock.
- `USB_RST` in 1: asynchronous, active-high reset.
- `USB_DATA` inout 16: FX2 FIFO data bus.
- `USB_ADDR` out 2: FIFOADR.
- `USB_SLRD`, `USB_SLWR`, `USB_SLOE`, `USB_PKEND` out 1 each: FX2 strobes, active-low.
- `USB_FLAGA` in 1: OUT endpoint not empty, high = data available.
- `USB_FLAGD` in 1: IN endpoint not full, high = space available.
- `RX_DATA` out 16, `RX_VALID` out 1, `RX_READY` in 1: host-to-device stream.
- `TX_DATA` in 16, `TX_LAST` in 1, `TX_VALID` in 1, `TX_READY` out 1: device-to-host stream.
- `STATE` out 4: current FSM state encoding, for debug.

## Operation
- **Internal buffers:** one 4-entry RX FIFO and one 4-entry TX FIFO (the TX FIFO also stores LAST).
  - RX side: `RX_VALID` = RX FIFO not empty; `RX_DATA` = RX head. A pop occurs on `RX_VALID & RX_READY`.
  - TX side: `TX_READY` = TX FIFO not full. A push occurs on `TX_VALID & TX_READY`.
- **FSM states and encodings:** IDLE=0, RD_SEL=1, RD=2, WR_SEL=3, WR=4, PKT=5, TURN=6.
- **IDLE:** round-robin arbitration, starting with read priority after reset.
  - A read is eligible when `FLAGA=1` and the RX FIFO has at least 2 free entries.
  - A write is eligible when the TX FIFO is non-empty and `FLAGD=1`.
  - If both are eligible, the direction not served last wins.
- **RD_SEL:** `ADDR=OUT_ADDR`, `SLOE=0`, `SLRD=1`; lasts 1 cycle, then RD.
- **RD:**
  - `SLRD` is registered and is low only while the RX FIFO has at least 2 free entries after this edge's push/pop.
  - A word is captured at an edge iff `SLRD=0`, `SLOE=0` and `FLAGA=1` at that edge.
  - Exit to TURN when `FLAGA=0` is sampled, when RX space is short, or after `BURST_MAX` captures.
- **TURN:** `SLOE=1`, `SLRD=1`, `SLWR=1`, bus tri-stated; lasts 1 cycle, then IDLE.
- **WR_SEL:** `ADDR=IN_ADDR`, `SLOE=1`; `USB_DATA` is driven with the TX head; lasts 1 cycle, then WR.
- **WR:**
  - `USB_DATA` = TX head, combinational.
  - `SLWR` is registered and is low iff the TX FIFO will be non-empty after this edge.
  - The head word is consumed iff `SLWR=0` and `FLAGD=1` at the edge.
  - A consumed word with LAST set moves to PKT (when enabled, see Configuration).
  - Otherwise exit to TURN on TX empty, `FLAGD=0`, or `BURST_MAX` words written.
- **PKT:** `SLWR=1`, `PKEND=0` for exactly 1 cycle, then TURN. A zero-length packet results if the packet boundary was already reached; this is accepted behaviour.
- **Bus ownership:** `USB_DATA` is driven only in WR_SEL, WR and PKT, never while `SLOE=0`.

## Timing
- **Reset values (asynchronous):**
  - `USB_SLRD`, `USB_SLWR`, `USB_SLOE`, `USB_PKEND` = 1.
  - `USB_ADDR=OUT_ADDR`, `USB_DATA`=Z, `STATE`=0.
  - Both FIFOs empty, so `RX_VALID=0` and `TX_READY=1`.
- Reset mid-burst takes effect immediately. The word in flight is dropped, with no partial strobe.
- **Read latency:**
  - Edge E0 samples `FLAGA=1` in IDLE.
  - E1 enters RD with `SLRD=0`.
  - E2 captures the first word; `RX_VALID=1` after E2.
  - Sustained rate is 1 word/cycle while `RX_READY=1`.
- **Write latency:** a TX push at E0 in IDLE gives first `SLWR=0` after E2 and consumption at E3. Sustained rate is 1 word/cycle.
- **Flags:** used unsynchronized (same clock as the FX2). Stale flags are harmless because every transfer is qualified by the flag at the same edge.
- **Simultaneous events:** RX push and pop in the same cycle keep the count; the same holds for TX. The burst counter is 9 bits, so `BURST_MAX=256` is reached without wrap.

## Configuration
- `FX2_PKTEND_EN`:
  - Defined: `TX_LAST` triggers the PKT state and a 1-cycle `USB_PKEND` low pulse after the last word.
  - Undefined: `TX_LAST` is ignored, PKT is unreachable, `USB_PKEND` is constant 1, and packets commit only by FX2 auto-commit.

## Test plan
- **Read drain:** OUT model preloaded with 0x0000..0x0004, `FLAGA` drops registered after the 5th read, `RX_READY=1` → RX delivers exactly 0x0000..0x0004 in order, then TURN→IDLE with `SLOE=1`.
- **Read backpressure:** 20 OUT words, `RX_READY=0` → at most 4 captures with `SLRD` high thereafter; release `RX_READY` → all 20 words delivered in order, no loss or duplication.
- **Write until full:** 300 TX words, IN model drops `FLAGD` after 256 → exactly 256 words stored, 0..255 in order; raise `FLAGD` → remaining 44 written.
- **Short packet:** 3 TX words 0xA1..0xA3 with `TX_LAST` on 0xA3 → 3 consumed strobes, then `PKEND=0` for 1 cycle with `SLWR=1`. Without the macro, `PKEND` stays 1.
- **Bidirectional traffic:** continuous OUT and TX traffic → bursts alternate with at least one TURN cycle between them, `USB_DATA` never driven while `SLOE=0`, and no burst exceeds 256 words.
- **Reset in WR:** assert `USB_RST` during a write burst → all strobes 1, `USB_DATA`=Z, `RX_VALID=0`, `TX_READY=1` immediately.

Source files
------------

// File: rtl/fx2_fifo_master.sv
// FX2 slave-FIFO master: drains the OUT endpoint into an RX stream and fills the IN endpoint from a TX stream.
// Define FX2_PKTEND_EN to commit short packets with a PKTEND pulse after a word tagged TX_LAST.
module fx2_fifo_master #(
    parameter logic [1:0] OUT_ADDR  = 2'b00,
    parameter logic [1:0] IN_ADDR   = 2'b10,
    parameter int         BURST_MAX = 256
) (
    input  logic        USB_IFCLK,
    input  logic        USB_RST,
    inout  wire  [15:0] USB_DATA,
    output logic [1:0]  USB_ADDR,
    output logic        USB_SLRD,
    output logic        USB_SLWR,
    output logic        USB_SLOE,
    output logic        USB_PKEND,
    input  logic        USB_FLAGA,
    input  logic        USB_FLAGD,
    output logic [15:0] RX_DATA,
    output logic        RX_VALID,
    input  logic        RX_READY,
    input  logic [15:0] TX_DATA,
    input  logic        TX_LAST,
    input  logic        TX_VALID,
    output logic        TX_READY,
    output logic [3:0]  STATE
);

`ifdef FX2_PKTEND_EN
    localparam logic PKTEND_EN = 1'b1;
`else
    localparam logic PKTEND_EN = 1'b0;
`endif

    localparam logic [8:0] BURST_LIM = 9'(BURST_MAX);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_RD_SEL = 4'd1,
        ST_RD     = 4'd2,
        ST_WR_SEL = 4'd3,
        ST_WR     = 4'd4,
        ST_PKT    = 4'd5,
        ST_TURN   = 4'd6
    } state_t;

    state_t      state_q, state_d;
    logic        slrd_q, slrd_d;
    logic        slwr_q, slwr_d;
    logic        sloe_q, sloe_d;
    logic        pkend_q, pkend_d;
    logic        drive_q, drive_d;
    logic [1:0]  addr_q, addr_d;
    logic [8:0]  burst_q, burst_d;
    logic        last_rd_q, last_rd_d;

    logic [15:0] rx_mem_q [0:3];
    logic [1:0]  rx_wr_ptr_q, rx_rd_ptr_q;
    logic [2:0]  rx_cnt_q, rx_cnt_d;
    logic        rx_push_s, rx_pop_s, rx_room_s;

    logic [16:0] tx_mem_q [0:3];
    logic [1:0]  tx_wr_ptr_q, tx_rd_ptr_q;
    logic [2:0]  tx_cnt_q, tx_cnt_d;
    logic        tx_push_s, tx_pop_s;
    logic [16:0] tx_head_s;

    logic        rd_elig_s, wr_elig_s;

    // A word moves only when the strobe and the flag agree at the same edge, so stale flags never lose data.
    assign rx_push_s = ~slrd_q & ~sloe_q & USB_FLAGA;
    assign rx_pop_s  = RX_VALID & RX_READY;
    assign tx_push_s = TX_VALID & TX_READY;
    assign tx_pop_s  = ~slwr_q & USB_FLAGD;
    assign tx_head_s = tx_mem_q[tx_rd_ptr_q];

    assign RX_VALID  = (rx_cnt_q != 3'd0);
    assign RX_DATA   = rx_mem_q[rx_rd_ptr_q];
    assign TX_READY  = (tx_cnt_q != 3'd4);

    assign USB_SLRD  = slrd_q;
    assign USB_SLWR  = slwr_q;
    assign USB_SLOE  = sloe_q;
    assign USB_PKEND = pkend_q;
    assign USB_ADDR  = addr_q;
    assign USB_DATA  = drive_q ? tx_head_s[15:0] : 16'hzzzz;
    assign STATE     = state_q;

    assign rd_elig_s = USB_FLAGA & (rx_cnt_q <= 3'd2);
    assign wr_elig_s = (tx_cnt_q != 3'd0) & USB_FLAGD;
    assign rx_room_s = (rx_cnt_d <= 3'd2);

    // FIFO occupancy after this edge's push/pop.
    always_comb begin
        rx_cnt_d = rx_cnt_q + {2'b00, rx_push_s} - {2'b00, rx_pop_s};
        tx_cnt_d = tx_cnt_q + {2'b00, tx_push_s} - {2'b00, tx_pop_s};
    end

    // FIFO storage arrays; contents are don't-care until the pointers say otherwise.
    always_ff @(posedge USB_IFCLK) begin
        if (rx_push_s) begin
            rx_mem_q[rx_wr_ptr_q] <= USB_DATA;
        end
        if (tx_push_s) begin
            tx_mem_q[tx_wr_ptr_q] <= {TX_LAST, TX_DATA};
        end
    end

    // FIFO pointers and counts.
    always_ff @(posedge USB_IFCLK or posedge USB_RST) begin
        if (USB_RST) begin
            rx_wr_ptr_q <= 2'd0;
            rx_rd_ptr_q <= 2'd0;
            rx_cnt_q    <= 3'd0;
            tx_wr_ptr_q <= 2'd0;
            tx_rd_ptr_q <= 2'd0;
            tx_cnt_q    <= 3'd0;
        end else begin
            if (rx_push_s) begin
                rx_wr_ptr_q <= rx_wr_ptr_q + 2'd1;
            end
            if (rx_pop_s) begin
                rx_rd_ptr_q <= rx_rd_ptr_q + 2'd1;
            end
            if (tx_push_s) begin
                tx_wr_ptr_q <= tx_wr_ptr_q + 2'd1;
            end
            if (tx_pop_s) begin
                tx_rd_ptr_q <= tx_rd_ptr_q + 2'd1;
            end
            rx_cnt_q <= rx_cnt_d;
            tx_cnt_q <= tx_cnt_d;
        end
    end

    // Bus FSM state and registered FX2 strobes.
    always_ff @(posedge USB_IFCLK or posedge USB_RST) begin
        if (USB_RST) begin
            state_q   <= ST_IDLE;
            slrd_q    <= 1'b1;
            slwr_q    <= 1'b1;
            sloe_q    <= 1'b1;
            pkend_q   <= 1'b1;
            drive_q   <= 1'b0;
            addr_q    <= OUT_ADDR;
            burst_q   <= 9'd0;
            last_rd_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            slrd_q    <= slrd_d;
            slwr_q    <= slwr_d;
            sloe_q    <= sloe_d;
            pkend_q   <= pkend_d;
            drive_q   <= drive_d;
            addr_q    <= addr_d;
            burst_q   <= burst_d;
            last_rd_q <= last_rd_d;
        end
    end

    // Next state and next strobe values; everything idles inactive unless a state asks otherwise.
    always_comb begin
        state_d   = state_q;
        slrd_d    = 1'b1;
        slwr_d    = 1'b1;
        sloe_d    = 1'b1;
        pkend_d   = 1'b1;
        drive_d   = 1'b0;
        addr_d    = addr_q;
        burst_d   = burst_q;
        last_rd_d = last_rd_q;

        case (state_q)
            ST_IDLE: begin
                // Round robin: on a tie, serve whichever direction did not go last.
                if (rd_elig_s && (!wr_elig_s || !last_rd_q)) begin
                    state_d   = ST_RD_SEL;
                    addr_d    = OUT_ADDR;
                    sloe_d    = 1'b0;
                    last_rd_d = 1'b1;
                end else if (wr_elig_s) begin
                    state_d   = ST_WR_SEL;
                    addr_d    = IN_ADDR;
                    drive_d   = 1'b1;
                    last_rd_d = 1'b0;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_RD_SEL: begin
                state_d = ST_RD;
                sloe_d  = 1'b0;
                slrd_d  = ~rx_room_s;
                burst_d = 9'd0;
            end
            ST_RD: begin
                burst_d = burst_q + {8'd0, rx_push_s};
                if (!USB_FLAGA || !rx_room_s || (burst_d == BURST_LIM)) begin
                    state_d = ST_TURN;
                end else begin
                    sloe_d  = 1'b0;
                    slrd_d  = 1'b0;
                end
            end
            ST_WR_SEL: begin
                state_d = ST_WR;
                drive_d = 1'b1;
                slwr_d  = (tx_cnt_d == 3'd0);
                burst_d = 9'd0;
            end
            ST_WR: begin
                burst_d = burst_q + {8'd0, tx_pop_s};
                if (tx_pop_s && PKTEND_EN && tx_head_s[16]) begin
                    state_d = ST_PKT;
                    drive_d = 1'b1;
                    pkend_d = 1'b0;
                end else if ((tx_cnt_d == 3'd0) || !USB_FLAGD || (burst_d == BURST_LIM)) begin
                    state_d = ST_TURN;
                end else begin
                    drive_d = 1'b1;
                    slwr_d  = 1'b0;
                end
            end
            ST_PKT: begin
                state_d = ST_TURN;
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fx2_fifo_master.sv
// Directed bench for fx2_fifo_master with behavioural FX2 OUT/IN endpoint models and stream scoreboards.
`timescale 1ns/1ps
module tb_fx2_fifo_master;

`ifdef FX2_PKTEND_EN
    localparam int EXP_PKEND = 1;
`else
    localparam int EXP_PKEND = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    wire  [15:0] usb_data;
    logic [1:0]  usb_addr;
    logic        usb_slrd, usb_slwr, usb_sloe, usb_pkend;
    logic        flaga, flagd;
    logic [15:0] rx_data;
    logic        rx_valid, rx_ready;
    logic [15:0] tx_data;
    logic        tx_last, tx_valid, tx_ready;
    logic [3:0]  state_o;

    logic [15:0] out_mem [0:1023];
    int          out_len, out_idx;
    logic [15:0] in_mem [0:1023];
    int          in_cnt, in_cap;
    logic [15:0] tx_src [0:1023];
    logic        tx_lst [0:1023];
    int          tx_len, tx_idx;
    int          rx_idx;
    logic        tb_bus_en;

    int n_total = 0;
    int n_bad   = 0;
    int contention, pkend_lows, pkend_bad, turn_viol, alt_viol;
    int bursts, rd_bursts, wr_bursts, cur_burst, max_burst;
    logic [3:0] last_active;
    logic       prev_rd;

    wire        tb_oe  = !usb_sloe || tb_bus_en;
    wire [15:0] tb_val = tb_bus_en ? 16'h0000 : out_mem[out_idx[9:0]];
    assign usb_data = tb_oe ? tb_val : 16'hzzzz;

    always #10 clk = ~clk;

    fx2_fifo_master dut (
        .USB_IFCLK (clk),
        .USB_RST   (rst),
        .USB_DATA  (usb_data),
        .USB_ADDR  (usb_addr),
        .USB_SLRD  (usb_slrd),
        .USB_SLWR  (usb_slwr),
        .USB_SLOE  (usb_sloe),
        .USB_PKEND (usb_pkend),
        .USB_FLAGA (flaga),
        .USB_FLAGD (flagd),
        .RX_DATA   (rx_data),
        .RX_VALID  (rx_valid),
        .RX_READY  (rx_ready),
        .TX_DATA   (tx_data),
        .TX_LAST   (tx_last),
        .TX_VALID  (tx_valid),
        .TX_READY  (tx_ready),
        .STATE     (state_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic init_models();
        out_len = 0; out_idx = 0; flaga = 1'b0;
        in_cnt = 0; in_cap = 0; flagd = 1'b0;
        tx_len = 0; tx_idx = 0; tx_valid = 1'b0; tx_data = 16'h0000; tx_last = 1'b0;
        rx_idx = 0; rx_ready = 1'b0; tb_bus_en = 1'b0;
        contention = 0; pkend_lows = 0; pkend_bad = 0; turn_viol = 0; alt_viol = 0;
        bursts = 0; rd_bursts = 0; wr_bursts = 0; cur_burst = 0; max_burst = 0;
        last_active = 4'd0; prev_rd = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            tx_lst[i] = 1'b0;
        end
    endtask

    task automatic restart();
        rst = 1'b1;
        init_models();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One clock: sample strobes at the negedge, then update the FX2 and stream models just after the edge.
    task automatic cycle();
        logic rd_x, wr_x, rx_t, tx_t;
        logic [15:0] wr_w, rx_w;
        logic [3:0] st;
        @(negedge clk);
        st   = state_o;
        rd_x = !usb_slrd && !usb_sloe && flaga;
        wr_x = !usb_slwr && flagd;
        wr_w = usb_data;
        rx_t = rx_valid && rx_ready;
        rx_w = rx_data;
        tx_t = tx_valid && tx_ready;
        if (!usb_sloe && (st == 4'd3 || st == 4'd4 || st == 4'd5)) contention++;
        if (!usb_pkend) begin
            pkend_lows++;
            if (!usb_slwr) pkend_bad++;
        end
        if (st == 4'd1 || st == 4'd3) begin
            if (bursts > 0) begin
                if (last_active != 4'd6) turn_viol++;
                if ((st == 4'd1) == prev_rd) alt_viol++;
            end
            bursts++;
            if (st == 4'd1) rd_bursts++;
            else wr_bursts++;
            prev_rd = (st == 4'd1);
            cur_burst = 0;
        end
        if (st != 4'd0) last_active = st;
        if (rd_x || wr_x) begin
            cur_burst++;
            if (cur_burst > max_burst) max_burst = cur_burst;
        end
        @(posedge clk);
        #1;
        if (rd_x) out_idx++;
        if (wr_x) begin
            in_mem[in_cnt[9:0]] = wr_w;
            in_cnt++;
        end
        if (rx_t) begin
            check_eq("rx_data", {16'h0, rx_w}, {16'h0, out_mem[rx_idx[9:0]]});
            rx_idx++;
        end
        if (tx_t) tx_idx++;
        flaga    = (out_idx < out_len);
        flagd    = (in_cnt < in_cap);
        tx_valid = (tx_idx < tx_len);
        tx_data  = tx_src[tx_idx[9:0]];
        tx_last  = tx_lst[tx_idx[9:0]];
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        rst = 1'b1;
        init_models();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_slrd", usb_slrd, 1);
        check_eq("rst_slwr", usb_slwr, 1);
        check_eq("rst_sloe", usb_sloe, 1);
        check_eq("rst_pkend", usb_pkend, 1);
        check_eq("rst_addr", usb_addr, 2'b00);
        check_eq("rst_state", state_o, 0);
        check_eq("rst_rx_valid", rx_valid, 0);
        check_eq("rst_tx_ready", tx_ready, 1);
        rst = 1'b0;
        cycle();
        check_eq("idle_state", state_o, 0);

        // Read drain: 5 words, then FLAGA falls
        restart();
        rx_ready = 1'b1;
        for (int i = 0; i < 5; i++) out_mem[i] = 16'(i);
        out_len = 5;
        flaga = 1'b1;
        cycle();
        check_eq("rdsel_state", state_o, 1);
        check_eq("rdsel_sloe", usb_sloe, 0);
        check_eq("rdsel_addr", usb_addr, 2'b00);
        cycle();
        check_eq("rd_state", state_o, 2);
        check_eq("rd_slrd", usb_slrd, 0);
        cycle();
        check_eq("rd_first_valid", rx_valid, 1);
        check_eq("rd_first_data", rx_data, 16'h0000);
        for (int i = 0; i < 50 && rx_idx < 5; i++) cycle();
        repeat (4) cycle();
        check_eq("drain_count", rx_idx, 5);
        check_eq("drain_reads", out_idx, 5);
        check_eq("drain_state", state_o, 0);
        check_eq("drain_sloe", usb_sloe, 1);

        // Read backpressure
        restart();
        for (int i = 0; i < 20; i++) out_mem[i] = 16'h1000 + 16'(i);
        out_len = 20;
        flaga = 1'b1;
        repeat (30) cycle();
        check_eq("bp_captures", out_idx, 3);
        check_eq("bp_slrd_high", usb_slrd, 1);
        check_eq("bp_rx_valid", rx_valid, 1);
        rx_ready = 1'b1;
        for (int i = 0; i < 400 && rx_idx < 20; i++) cycle();
        repeat (4) cycle();
        check_eq("bp_delivered", rx_idx, 20);
        check_eq("bp_reads", out_idx, 20);

        // Write until full, with first-word latency
        restart();
        for (int i = 0; i < 300; i++) tx_src[i] = 16'(i);
        tx_len = 300;
        in_cap = 256;
        flagd = 1'b1;
        tx_valid = 1'b1;
        tx_data = tx_src[0];
        cycle();
        cycle();
        check_eq("wrsel_state", state_o, 3);
        check_eq("wrsel_addr", usb_addr, 2'b10);
        cycle();
        check_eq("wr_state", state_o, 4);
        check_eq("wr_slwr", usb_slwr, 0);
        cycle();
        check_eq("wr_first_cnt", in_cnt, 1);
        for (int i = 0; i < 1500 && in_cnt < 256; i++) cycle();
        repeat (20) cycle();
        check_eq("full_cnt", in_cnt, 256);
        check_eq("full_state", state_o, 0);
        check_eq("full_max_burst", max_burst, 256);
        for (int i = 0; i < 256; i++) check_eq("full_word", in_mem[i], 16'(i));
        in_cap = 1000;
        for (int i = 0; i < 1500 && in_cnt < 300; i++) cycle();
        repeat (10) cycle();
        check_eq("rest_cnt", in_cnt, 300);
        for (int i = 256; i < 300; i++) check_eq("rest_word", in_mem[i], 16'(i));

        // Short packet
        restart();
        tx_src[0] = 16'h00A1; tx_src[1] = 16'h00A2; tx_src[2] = 16'h00A3;
        tx_lst[2] = 1'b1;
        tx_len = 3;
        in_cap = 1000;
        flagd = 1'b1;
        tx_valid = 1'b1;
        tx_data = tx_src[0];
        for (int i = 0; i < 100 && in_cnt < 3; i++) cycle();
        repeat (8) cycle();
        check_eq("pkt_cnt", in_cnt, 3);
        check_eq("pkt_w0", in_mem[0], 16'h00A1);
        check_eq("pkt_w1", in_mem[1], 16'h00A2);
        check_eq("pkt_w2", in_mem[2], 16'h00A3);
        check_eq("pkt_pkend_pulses", pkend_lows, EXP_PKEND);
        check_eq("pkt_pkend_slwr", pkend_bad, 0);
        check_eq("pkt_idle", state_o, 0);

        // Bidirectional traffic
        restart();
        for (int i = 0; i < 600; i++) begin
            out_mem[i] = 16'h8000 + 16'(i);
            tx_src[i]  = 16'h4000 + 16'(i);
        end
        out_len = 600;
        tx_len = 600;
        in_cap = 2000;
        rx_ready = 1'b1;
        flaga = 1'b1;
        flagd = 1'b1;
        tx_valid = 1'b1;
        tx_data = tx_src[0];
        for (int i = 0; i < 6000 && (rx_idx < 600 || in_cnt < 600); i++) cycle();
        repeat (5) cycle();
        check_eq("bi_rx_cnt", rx_idx, 600);
        check_eq("bi_in_cnt", in_cnt, 600);
        for (int i = 0; i < 600; i++) check_eq("bi_in_word", in_mem[i], 16'h4000 + 16'(i));
        check_eq("bi_contention", contention, 0);
        check_eq("bi_turn", turn_viol, 0);
        check_eq("bi_alternate", alt_viol, 0);
        check_eq("bi_max_burst", max_burst, 256);
        check_eq("bi_rd_bursts", rd_bursts, 3);
        check_eq("bi_wr_bursts", wr_bursts, 3);

        // Reset during a write burst
        restart();
        for (int i = 0; i < 100; i++) tx_src[i] = 16'h7700 + 16'(i);
        tx_len = 100;
        in_cap = 1000;
        flagd = 1'b1;
        tx_valid = 1'b1;
        tx_data = tx_src[0];
        for (int i = 0; i < 100 && in_cnt < 10; i++) cycle();
        check_eq("wrst_pre_state", state_o, 4);
        check_eq("wrst_pre_slwr", usb_slwr, 0);
        #3;
        rst = 1'b1;
        tb_bus_en = 1'b1;
        #1;
        check_eq("wrst_slrd", usb_slrd, 1);
        check_eq("wrst_slwr", usb_slwr, 1);
        check_eq("wrst_sloe", usb_sloe, 1);
        check_eq("wrst_pkend", usb_pkend, 1);
        check_eq("wrst_rx_valid", rx_valid, 0);
        check_eq("wrst_tx_ready", tx_ready, 1);
        check_eq("wrst_state", state_o, 0);
        check_eq("wrst_bus_free", usb_data, 16'h0000);
        tb_bus_en = 1'b0;
        tx_valid = 1'b0;
        tx_len = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
